or1200_rfe_ctrl: RTL and testbench

Return-from-exception sequencer for the OR1200 CPU. It is the exit path of the exception mechanism, the counterpart to exception entry. When l.rfe reaches EX, it restores SR from ESR, redirects the PC to EPCR, flushes the pipe, waits for the first fetch at the return address, and waits for IF/ID to settle before releasing the pipeline. It sits beside the exception unit and arbitrates against it: exception entry always wins.

---
 rtl/or1200_rfe_ctrl.sv | 142 ++++++++++++++
 tb/tb_or1200_rfe_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_rfe_ctrl.sv
// Return-from-exception sequencer: restores SR from ESR, redirects PC to EPCR,
// flushes the pipe and holds busy until the return fetch lands and IF/ID settle.
module or1200_rfe_ctrl #(
  parameter int PC_WIDTH  = 32,
  parameter int SR_WIDTH  = 16,
  parameter int TMO_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_rfe_i,
  input  logic                ex_freeze_i,
  input  logic                except_busy_i,
  input  logic [PC_WIDTH-1:0] epcr_i,
  input  logic [SR_WIDTH-1:0] esr_i,
  input  logic                icpu_ack_i,
  input  logic                icpu_err_i,
  input  logic                genpc_freeze_i,
  input  logic                if_stall_i,
  input  logic                id_freeze_i,
  output logic                rfe_flushpipe_o,
  output logic                rfe_pc_we_o,
  output logic [PC_WIDTH-1:0] rfe_pc_o,
  output logic                sr_we_o,
  output logic [SR_WIDTH-1:0] sr_o,
  output logic                rfe_busy_o,
  output logic                rfe_err_o,
  output logic                rfe_align_o,
  output logic                rfe_abort_o,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_FETCH  = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  localparam logic [TMO_WIDTH-1:0] TMO_MAX = '1;

  state_t                state_q;
  logic [TMO_WIDTH-1:0]  cnt_q;
  logic [TMO_WIDTH-1:0]  cnt_d;
  logic                  flush_q;
  logic                  pc_we_q;
  logic                  sr_we_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [SR_WIDTH-1:0]   sr_q;
  logic                  err_q;
  logic                  align_q;
  logic                  abort_q;
  logic                  accept;
  logic                  misaligned;

  assign accept     = ex_rfe_i && !ex_freeze_i && !except_busy_i;
  assign misaligned = (epcr_i[1:0] != 2'b00);
  assign cnt_d      = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      pc_we_q <= 1'b0;
      sr_we_q <= 1'b0;
      pc_q    <= '0;
      sr_q    <= '0;
      err_q   <= 1'b0;
      align_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      pc_we_q <= 1'b0;
      sr_we_q <= 1'b0;
      err_q   <= 1'b0;
      align_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (misaligned) begin
              align_q <= 1'b1;
            end else begin
              pc_q    <= {epcr_i[PC_WIDTH-1:2], 2'b00};
              sr_q    <= esr_i;
              flush_q <= 1'b1;
              pc_we_q <= 1'b1;
              sr_we_q <= 1'b1;
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          cnt_q   <= '0;
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          // Exception entry outranks everything; ack outranks the timeout.
          cnt_q <= cnt_d;
          if (except_busy_i) begin
            abort_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (icpu_err_i) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (icpu_ack_i || genpc_freeze_i) begin
            state_q <= S_SETTLE;
          end else if (cnt_d == TMO_MAX) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (except_busy_i) begin
            abort_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (!if_stall_i && !id_freeze_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rfe_flushpipe_o = flush_q;
  assign rfe_pc_we_o     = pc_we_q;
  assign sr_we_o         = sr_we_q;
  assign rfe_pc_o        = pc_q;
  assign sr_o            = sr_q;
  assign rfe_err_o       = err_q;
  assign rfe_align_o     = align_q;
  assign rfe_abort_o     = abort_q;
  assign rfe_busy_o      = (state_q != S_IDLE);
  assign state_o         = state_q;

  a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({err_q, align_q, abort_q, flush_q}));
  a_pulse_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (err_q || align_q || abort_q) |-> (state_q == S_IDLE));

endmodule

// File: tb/tb_or1200_rfe_ctrl.sv
// Randomized bench for or1200_rfe_ctrl against a cycle-level behavioural model.
module tb_or1200_rfe_ctrl;

  localparam int PW = 32;
  localparam int SW = 16;
  localparam int TW = 4;
  localparam int TMO_CYC = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_rfe, ex_freeze, except_busy;
  logic [PW-1:0] epcr;
  logic [SW-1:0] esr;
  logic          ack, ierr, gfreeze, if_stall, id_freeze;
  logic          flush, pc_we, sr_we, busy, err, align, abort;
  logic [PW-1:0] rpc;
  logic [SW-1:0] sr;
  logic [1:0]    state;

  or1200_rfe_ctrl #(.PC_WIDTH(PW), .SR_WIDTH(SW), .TMO_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_rfe_i(ex_rfe), .ex_freeze_i(ex_freeze),
    .except_busy_i(except_busy), .epcr_i(epcr), .esr_i(esr),
    .icpu_ack_i(ack), .icpu_err_i(ierr), .genpc_freeze_i(gfreeze),
    .if_stall_i(if_stall), .id_freeze_i(id_freeze),
    .rfe_flushpipe_o(flush), .rfe_pc_we_o(pc_we), .rfe_pc_o(rpc),
    .sr_we_o(sr_we), .sr_o(sr), .rfe_busy_o(busy), .rfe_err_o(err),
    .rfe_align_o(align), .rfe_abort_o(abort), .state_o(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 flush, 2 waiting for fetch, 3 settling.
  int            m_phase;
  int            m_fetches;
  bit            m_flush, m_err, m_align, m_abort;
  logic [PW-1:0] m_pc;
  logic [SW-1:0] m_sr;

  task automatic model_reset();
    m_phase = 0; m_fetches = 0;
    m_flush = 0; m_err = 0; m_align = 0; m_abort = 0;
    m_pc = '0; m_sr = '0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_flush = 0; m_err = 0; m_align = 0; m_abort = 0;
    case (m_phase)
      0: if (ex_rfe && !ex_freeze && !except_busy) begin
           if (epcr % 4 != 0) m_align = 1;
           else begin
             m_pc = epcr; m_sr = esr; m_flush = 1; m_phase = 1;
           end
         end
      1: begin m_phase = 2; m_fetches = 0; end
      2: begin
           m_fetches++;
           if (except_busy) begin m_abort = 1; m_phase = 0; end
           else if (ierr) begin m_err = 1; m_phase = 0; end
           else if (ack || gfreeze) m_phase = 3;
           else if (m_fetches == TMO_CYC) begin m_err = 1; m_phase = 0; end
         end
      default: begin
           if (except_busy) begin m_abort = 1; m_phase = 0; end
           else if (!if_stall && !id_freeze) m_phase = 0;
         end
    endcase
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".state"}, state, m_phase);
    chk({pfx, ".busy"}, busy, m_phase != 0);
    chk({pfx, ".flush"}, flush, m_flush);
    chk({pfx, ".pc_we"}, pc_we, m_flush);
    chk({pfx, ".sr_we"}, sr_we, m_flush);
    chk({pfx, ".pc"}, rpc, m_pc);
    chk({pfx, ".sr"}, sr, m_sr);
    chk({pfx, ".err"}, err, m_err);
    chk({pfx, ".align"}, align, m_align);
    chk({pfx, ".abort"}, abort, m_abort);
  endtask

  task automatic tick(input string pfx);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(pfx);
  endtask

  task automatic quiet();
    ex_rfe = 0; ex_freeze = 0; except_busy = 0; ack = 0; ierr = 0;
    gfreeze = 0; if_stall = 0; id_freeze = 0;
  endtask

  task automatic start_rfe(input logic [PW-1:0] pc, input logic [SW-1:0] s);
    quiet(); ex_rfe = 1; epcr = pc; esr = s;
  endtask

  int mode;

  initial begin
    rst_n = 0; epcr = '0; esr = '0;
    quiet();
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1;
    tick("idle");

    // Basic return
    start_rfe(32'h0000_2004, 16'h8001);
    tick("basic_acc");
    chk("basic_flush", flush, 1'b1);
    chk("basic_pc_const", rpc, 32'h0000_2004);
    chk("basic_sr_const", sr, 16'h8001);
    ex_rfe = 0; ack = 1;
    tick("basic_fetch");
    tick("basic_settle");
    ack = 0;
    tick("basic_done");
    chk("basic_idle_n4", state, 2'd0);

    // Back-to-back with misaligned EPCR
    start_rfe(32'h0000_2006, 16'h1234);
    tick("align");
    chk("align_pulse", align, 1'b1);
    chk("align_noflush", flush, 1'b0);
    quiet();
    tick("align_after");

    // Bus error together with ack on first fetch
    start_rfe(32'h0000_3000, 16'h0005);
    tick("berr_acc");
    quiet(); ack = 1; ierr = 1;
    tick("berr_fetch");
    tick("berr_out");
    chk("berr_pulse", err, 1'b1);
    quiet();

    // Timeout
    start_rfe(32'h0000_4000, 16'h00aa);
    tick("tmo_acc");
    quiet();
    tick("tmo_fetch");
    for (int i = 1; i <= TMO_CYC; i++) begin
      tick("tmo");
      chk("tmo_err", err, i == TMO_CYC);
    end

    // Abort during SETTLE with IF stalled
    start_rfe(32'h0000_5000, 16'h0101);
    tick("abt_acc");
    quiet(); ack = 1; if_stall = 1;
    tick("abt_fetch");
    tick("abt_settle");
    ack = 0;
    tick("abt_hold");
    except_busy = 1;
    tick("abt");
    chk("abt_pulse", abort, 1'b1);
    quiet();

    // Blocked by exception entry, then reset in FETCH
    start_rfe(32'h0000_6000, 16'h0202);
    except_busy = 1;
    tick("blocked");
    chk("blocked_state", state, 2'd0);
    except_busy = 0;
    tick("rst_acc");
    quiet();
    tick("rst_fetch");
    rst_n = 0;
    #1;
    model_reset();
    check_all("rst_async");
    tick("rst_hold");
    rst_n = 1;

    // Randomized traffic
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) mode = $urandom_range(0, 2);
      ex_rfe      = ($urandom_range(0, 1) == 0);
      ex_freeze   = ($urandom_range(0, 7) == 0);
      except_busy = (mode != 1) && ($urandom_range(0, 15) == 0);
      ack         = (mode == 0) && ($urandom_range(0, 3) == 0);
      ierr        = (mode != 1) && ($urandom_range(0, 19) == 0);
      gfreeze     = (mode == 2) && ($urandom_range(0, 9) == 0);
      if_stall    = ($urandom_range(0, 1) == 0);
      id_freeze   = ($urandom_range(0, 3) == 0);
      epcr        = $urandom;
      if ($urandom_range(0, 3) != 0) epcr[1:0] = 2'b00;
      esr         = SW'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 0;
        #1;
        model_reset();
        check_all("rnd_rst");
        tick("rnd_rst_hold");
        rst_n = 1;
      end else begin
        tick("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
